// File: rtl/rr_arb_pkg.sv
// Shared constants for the round-robin arbiter slice.
// Holds the default requester count and lock mode used by rr_arb.
package rr_arb_pkg;

    localparam int RR_W    = 4;
    localparam bit RR_LOCK = 1'b1;

endpackage

// File: rtl/rr_arb_pri.sv
// pri: first-one detector, one-hot output of the lowest set request bit.
// Ports: i_req [W-1:0] request vector, o_gnt [W-1:0] one-hot (zero if none).
module pri
    import rr_arb_pkg::*;
#(
    parameter int W = RR_W
) (
    input  logic [W-1:0] i_req,
    output logic [W-1:0] o_gnt
);

    logic found;

    always_comb begin
        o_gnt = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i_req[i] && !found) begin
                o_gnt[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter with registered grant held for a transaction.
// Ports: clk, arst_n, i_req[W], i_ack, i_last -> o_gnt[W], o_gnt_vld, o_gnt_idx.
module rr_arb
    import rr_arb_pkg::*;
#(
    parameter int W    = RR_W,
    parameter bit LOCK = RR_LOCK
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic [W-1:0]         i_req,
    input  logic                 i_ack,
    input  logic                 i_last,
    output logic [W-1:0]         o_gnt,
    output logic                 o_gnt_vld,
    output logic [$clog2(W)-1:0] o_gnt_idx
);

    localparam int IW = $clog2(W);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t       state;
    logic [W-1:0] mask;
    logic [W-1:0] masked;
    logic [W-1:0] m_gnt;
    logic [W-1:0] u_gnt;
    logic [W-1:0] win;
    logic [W-1:0] win_mask;
    logic [IW-1:0] win_idx;
    logic         done;

    function automatic logic [IW-1:0] enc(input logic [W-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (oh[i]) r |= i[IW-1:0];
        end
        return r;
    endfunction

    // Bits strictly above the winner; all-zero after the top index,
    // which hands the next pick to the unmasked path.
    function automatic logic [W-1:0] above(input logic [W-1:0] oh);
        logic [W-1:0] m;
        logic         seen;
        m    = '0;
        seen = 1'b0;
        for (int i = 0; i < W; i++) begin
            m[i] = seen;
            seen = seen | oh[i];
        end
        return m;
    endfunction

    assign masked = i_req & mask;

    pri #(.W(W)) u_pri_m (
        .i_req (masked),
        .o_gnt (m_gnt)
    );

    pri #(.W(W)) u_pri_u (
        .i_req (i_req),
        .o_gnt (u_gnt)
    );

    assign win      = (|masked) ? m_gnt : u_gnt;
    assign win_mask = above(win);
    assign win_idx  = enc(win);

    // Without lock every accepted beat ends the grant.
    assign done = (state == BUSY) && i_ack && (i_last || !LOCK);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            mask      <= '1;
            o_gnt     <= '0;
            o_gnt_vld <= 1'b0;
            o_gnt_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|i_req) begin
                        state     <= BUSY;
                        mask      <= win_mask;
                        o_gnt     <= win;
                        o_gnt_vld <= 1'b1;
                        o_gnt_idx <= win_idx;
                    end
                end
                BUSY: begin
                    if (done) begin
                        if (|i_req) begin
                            mask      <= win_mask;
                            o_gnt     <= win;
                            o_gnt_vld <= 1'b1;
                            o_gnt_idx <= win_idx;
                        end else begin
                            state     <= IDLE;
                            o_gnt     <= '0;
                            o_gnt_vld <= 1'b0;
                            o_gnt_idx <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_ack_vld : assert property (
        @(posedge clk) disable iff (!arst_n)
        i_ack |-> o_gnt_vld
    );

    // The grantee may drop its request on the completing beat.
    a_hold_req : assert property (
        @(posedge clk) disable iff (!arst_n)
        (state == BUSY && !done) |-> ((o_gnt & ~i_req) == '0)
    );

    a_onehot : assert property (
        @(posedge clk) disable iff (!arst_n)
        $onehot0(o_gnt)
    );

    a_idx : assert property (
        @(posedge clk) disable iff (!arst_n)
        o_gnt_idx == enc(o_gnt)
    );

    a_vld : assert property (
        @(posedge clk) disable iff (!arst_n)
        o_gnt_vld == (state == BUSY)
    );

endmodule

// File: doc/rr_arb.md
Name: rr_arb

Overview:
- Round-robin arbiter that shares one downstream resource (e.g. a shared write port or bus) among W requesters.
- Winner selection uses two `pri` first-one detector instances: one on the masked request vector, one on the unmasked vector.
- Grant is registered and held for a full multi-beat transaction, terminated by ack+last.
- Sits between requesting agents and a single-ported shared resource.

Parameters:
- W, 4, number of requesters (W >= 2).
- LOCK, 1'b1, 1: hold grant until i_ack & i_last; 0: release after every i_ack (i_last ignored).

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- i_req  in  W  per-requester request level; a requester must hold it until its transaction completes.
- i_ack  in  1  resource accepted the current beat from the granted requester.
- i_last  in  1  qualifies i_ack as the final beat; used only when LOCK=1.
- o_gnt  out  W  one-hot registered grant; zero when idle.
- o_gnt_vld  out  1  OR of o_gnt.
- o_gnt_idx  out  $clog2(W)  binary index of the granted requester; 0 when idle.

Behaviour:
- Reset (async assert): o_gnt=0, o_gnt_vld=0, o_gnt_idx=0, state=IDLE, priority mask=all ones (index 0 highest). Reset mid-transaction abandons the grant immediately.
- Priority rule: `pri` returns the lowest-index set bit.
  - masked = i_req & mask.
  - Winner = pri(masked) if masked != 0, else pri(i_req).
- Mask update: after granting index k, mask = bits strictly above k (k+1..W-1 set). If k=W-1, mask = 0, so the unmasked path selects next.
- FSM states: IDLE, BUSY.
- IDLE:
  - i_req != 0: at next edge register o_gnt=winner, update mask, go to BUSY. Latency is 1 cycle from request to grant.
  - i_req == 0: stay in IDLE with outputs 0.
- BUSY, no completion: hold o_gnt unchanged regardless of i_req changes.
- Completion event: i_ack & (i_last | !LOCK).
  - On completion with i_req excluding the current grantee non-zero, or the grantee still requesting: register a new winner the same edge (back-to-back, no idle bubble). The winner uses i_req at that cycle and the mask already updated for the completing grant, so a still-requesting grantee ranks last.
  - On completion with i_req == 0: o_gnt=0, go to IDLE. Mask is retained.
- i_ack while o_gnt_vld=0: ignored. Assertion: i_ack implies o_gnt_vld.
- Granted requester dropping i_req before completion is a protocol violation. Assertion: (o_gnt & ~i_req) == 0 while BUSY. Grant is still held.
- Invariants (asserted):
  - o_gnt is one-hot or zero.
  - o_gnt_idx == encode(o_gnt).
  - o_gnt_vld == (state==BUSY).
- Fairness: with all W requesting continuously, each requester receives exactly one grant in any W consecutive grants.

Decomposition:
- No new package types. State enum {IDLE, BUSY} is module-local.
- One-hot-to-binary encode is a local function; promote it to the common package only if a second user appears.
- Instantiate the existing `pri` module twice (masked and unmasked paths); no new sub-module.

Test Plan:
- Reset/idle: arst_n low with i_req=4'b1111 -> o_gnt=0, o_gnt_vld=0. Release, i_req=4'b0100 -> one cycle later o_gnt=4'b0100, o_gnt_idx=2.
- Rotation, LOCK=1: i_req=4'b1111 held, pulse i_ack&i_last once per grant -> grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles between grants.
- Multi-beat hold: grant 4'b0010, three i_ack beats with i_last=0 while i_req=4'b1111 -> o_gnt stays 4'b0010. Fourth beat with i_last=1 -> next cycle o_gnt=4'b0100.
- Wrap and skip: last grant index 3, i_req=4'b1001 -> next grant 4'b0001. Then complete with i_req=4'b1001 -> grant 4'b1000.
- LOCK=0: i_req=4'b0011, i_ack every cycle with i_last=0 -> grant alternates 0001, 0010 each cycle.
- Async reset mid-BUSY: assert arst_n between clock edges while o_gnt=4'b1000 -> o_gnt=0 immediately. After release with i_req=4'b1111 -> grant 4'b0001 (mask reset).
